// File: rtl/tinyriscv_pkg.sv
// Shared widths, constants and types for the tinyriscv IF/ID stage.
// Used by if_id_skid, whose buffered build is selected by IF_ID_SKID_EN.
package tinyriscv_pkg;

    localparam int unsigned InstBus       = 32;
    localparam int unsigned InstAddrBus   = 32;
    localparam int unsigned Hold_Flag_Bus = 3;

    localparam logic [InstBus-1:0]       INST_NOP   = 32'h0000_0013;
    localparam logic [Hold_Flag_Bus-1:0] Pipe_Clear = 3'b100;

    typedef struct packed {
        logic [InstBus-1:0]     inst;
        logic [InstAddrBus-1:0] addr;
        logic                   next_type;
    } if_id_entry_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_PART  = 2'b01,
        SKID_FULL  = 2'b10
    } skid_state_e;

endpackage

// File: rtl/gen_skid_buf.sv
// Generic circular skid FIFO (1..2 entries) with push/pop/flush and occupancy state.
// Instantiated by if_id_skid only when IF_ID_SKID_EN is defined.
module gen_skid_buf
    import tinyriscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = if_id_entry_t
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  T            data_i,
    output T            data_o,
    output skid_state_e state_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam ptr_t PTR_LAST = ptr_t'(DEPTH - 1);
    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

    T            r_mem [DEPTH];
    ptr_t        r_rptr;
    ptr_t        r_wptr;
    cnt_t        r_count;
    skid_state_e r_state;

    ptr_t        w_rptr_nxt;
    ptr_t        w_wptr_nxt;
    cnt_t        w_count_nxt;
    skid_state_e w_state_nxt;
    logic        w_do_push;
    logic        w_do_pop;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_do_push   = push_i & (r_state != SKID_FULL);
        w_do_pop    = pop_i & (r_state != SKID_EMPTY);
        w_rptr_nxt  = r_rptr;
        w_wptr_nxt  = r_wptr;
        w_count_nxt = r_count;
        w_state_nxt = r_state;

        // Flush wins over any push/pop presented in the same cycle.
        if (flush_i) begin
            w_rptr_nxt  = '0;
            w_wptr_nxt  = '0;
            w_count_nxt = '0;
        end else begin
            if (w_do_push) w_wptr_nxt = ptr_inc(r_wptr);
            if (w_do_pop)  w_rptr_nxt = ptr_inc(r_rptr);
            case ({w_do_push, w_do_pop})
                2'b10:   w_count_nxt = r_count + 1'b1;
                2'b01:   w_count_nxt = r_count - 1'b1;
                default: w_count_nxt = r_count;
            endcase
        end

        if (w_count_nxt == '0)           w_state_nxt = SKID_EMPTY;
        else if (w_count_nxt == CNT_FULL) w_state_nxt = SKID_FULL;
        else                             w_state_nxt = SKID_PART;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
            r_state <= SKID_EMPTY;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_rptr  <= w_rptr_nxt;
            r_wptr  <= w_wptr_nxt;
            r_count <= w_count_nxt;
            r_state <= w_state_nxt;
            if (!flush_i && w_do_push) begin
                r_mem[r_wptr] <= data_i;
            end
        end
    end

    assign data_o  = r_mem[r_rptr];
    assign state_o = r_state;

endmodule

// File: rtl/if_id_skid.sv
// IF->ID stage: skid buffer when IF_ID_SKID_EN is defined, else one pipeline register.
// Handshake decode and NOP substitution on an empty head live here.
module if_id_skid
    import tinyriscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     inst_valid_i,
    input  logic [InstBus-1:0]       inst_i,
    input  logic [InstAddrBus-1:0]   inst_addr_i,
    input  logic                     inst_addr_next_type_i,
    output logic                     ready_if_o,
    input  logic [Hold_Flag_Bus-1:0] hold_flag_i,
    input  logic                     ready_id_ex_i,
    output logic                     valid_if_id_o,
    output logic [InstBus-1:0]       inst_o,
    output logic [InstAddrBus-1:0]   inst_addr_o,
    output logic                     inst_addr_next_type_o
);

    if (DEPTH < 1 || DEPTH > 2) begin : g_bad_depth
        $error("if_id_skid: DEPTH must be 1 or 2");
    end

    if_id_entry_t w_in;
    if_id_entry_t w_head;
    logic         w_valid;
    logic         w_flush;
    logic         w_push;
    logic         w_pop;

    assign w_in    = '{inst: inst_i, addr: inst_addr_i, next_type: inst_addr_next_type_i};
    assign w_flush = (hold_flag_i == Pipe_Clear);
    assign w_push  = inst_valid_i & ready_if_o;
    assign w_pop   = w_valid & ready_id_ex_i;

`ifdef IF_ID_SKID_EN
    skid_state_e w_state;

    gen_skid_buf #(
        .DEPTH (DEPTH),
        .T     (if_id_entry_t)
    ) u_skid_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .flush_i (w_flush),
        .data_i  (w_in),
        .data_o  (w_head),
        .state_o (w_state)
    );

    // Ready comes from registered state only, so no path from ready_id_ex_i.
    assign ready_if_o = (w_state != SKID_FULL);
    assign w_valid    = (w_state != SKID_EMPTY);
`else
    if_id_entry_t r_entry;
    logic         r_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_entry <= '0;
            r_valid <= 1'b0;
        end else if (w_flush) begin
            r_entry <= '0;
            r_valid <= 1'b0;
        end else if (w_push) begin
            r_entry <= w_in;
            r_valid <= 1'b1;
        end else if (w_pop) begin
            r_entry <= '0;
            r_valid <= 1'b0;
        end
    end

    assign w_head     = r_entry;
    assign w_valid    = r_valid;
    assign ready_if_o = ready_id_ex_i | ~r_valid;
`endif

    always_comb begin
        valid_if_id_o         = w_valid;
        inst_o                = INST_NOP;
        inst_addr_o           = '0;
        inst_addr_next_type_o = 1'b0;
        if (w_valid) begin
            inst_o                = w_head.inst;
            inst_addr_o           = w_head.addr;
            inst_addr_next_type_o = w_head.next_type;
        end
    end

endmodule

// File: tb/tb_if_id_skid.sv
// Self-checking bench for if_id_skid against a queue-based model; honours IF_ID_SKID_EN.
module tb_if_id_skid;
    import tinyriscv_pkg::*;

    localparam int unsigned DEPTH = 2;
`ifdef IF_ID_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     inst_valid;
    logic [InstBus-1:0]       inst;
    logic [InstAddrBus-1:0]   inst_addr;
    logic                     next_type;
    logic                     ready_if;
    logic [Hold_Flag_Bus-1:0] hold_flag;
    logic                     ready_id_ex;
    logic                     valid_if_id;
    logic [InstBus-1:0]       inst_out;
    logic [InstAddrBus-1:0]   addr_out;
    logic                     next_type_out;

    int n_checks = 0;
    int n_errors = 0;

    if_id_entry_t model_q[$];

    always #5 clk = ~clk;

    if_id_skid #(.DEPTH(DEPTH)) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .inst_valid_i          (inst_valid),
        .inst_i                (inst),
        .inst_addr_i           (inst_addr),
        .inst_addr_next_type_i (next_type),
        .ready_if_o            (ready_if),
        .hold_flag_i           (hold_flag),
        .ready_id_ex_i         (ready_id_ex),
        .valid_if_id_o         (valid_if_id),
        .inst_o                (inst_out),
        .inst_addr_o           (addr_out),
        .inst_addr_next_type_o (next_type_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_ready(input logic rdy);
        if (SKID) return model_q.size() < DEPTH;
        return rdy || (model_q.size() == 0);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(valid_if_id), 32'd0);
        check({tag, "_ready"}, 32'(ready_if), 32'd1);
        check({tag, "_inst"}, inst_out, INST_NOP);
        check({tag, "_addr"}, addr_out, 32'd0);
        check({tag, "_nt"}, 32'(next_type_out), 32'd0);
    endtask

    // Called just after a posedge; returns with time just after the next posedge.
    task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] addr,
                         input logic nt, input logic [2:0] hold, input logic rdy,
                         output bit acc);
        bit           er;
        bit           ev;
        if_id_entry_t e;
        inst_valid  = iv;
        inst        = ins;
        inst_addr   = addr;
        next_type   = nt;
        hold_flag   = hold;
        ready_id_ex = rdy;
        @(negedge clk);
        er = model_ready(rdy);
        ev = (model_q.size() != 0);
        check("ready", 32'(ready_if), 32'(er));
        check("valid", 32'(valid_if_id), 32'(ev));
        if (ev) begin
            check("inst", inst_out, model_q[0].inst);
            check("addr", addr_out, model_q[0].addr);
            check("nt", 32'(next_type_out), 32'(model_q[0].next_type));
        end else begin
            check("inst_nop", inst_out, INST_NOP);
            check("addr_zero", addr_out, 32'd0);
            check("nt_zero", 32'(next_type_out), 32'd0);
        end
        @(posedge clk);
        acc = iv && er && (hold != Pipe_Clear);
        if (hold == Pipe_Clear) begin
            model_q.delete();
        end else begin
            if (ev && rdy) void'(model_q.pop_front());
            if (iv && er) begin
                e.inst      = ins;
                e.addr      = addr;
                e.next_type = nt;
                model_q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle(input logic rdy);
        bit acc;
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 3'b000, rdy, acc);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        bit seen20;
        int tries;

        rst_n       = 1'b0;
        inst_valid  = 1'b0;
        inst        = '0;
        inst_addr   = '0;
        next_type   = 1'b0;
        hold_flag   = 3'b000;
        ready_id_ex = 1'b0;
        #3;
        check_reset_outputs("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(1'b0);
        idle(1'b1);

        // Streaming with downstream always ready.
        cycle(1'b1, 32'h00500093, 32'h0, 1'b0, 3'b000, 1'b1, acc);
        check("stream_acc0", 32'(acc), 32'd1);
        cycle(1'b1, 32'h00a00113, 32'h4, 1'b1, 3'b000, 1'b1, acc);
        check("stream_acc1", 32'(acc), 32'd1);
        idle(1'b1);
        idle(1'b1);

        // Back-pressure: offer 0x8, 0xC, 0x10 with ready low, then release.
        cycle(1'b1, 32'h00000013, 32'h8, 1'b0, 3'b000, 1'b0, acc);
        cycle(1'b1, 32'h00100013, 32'hC, 1'b0, 3'b000, 1'b0, acc);
        check("bp_acc_c", 32'(acc), SKID ? 32'd1 : 32'd0);
        if (!acc) cycle(1'b1, 32'h00100013, 32'hC, 1'b0, 3'b000, 1'b1, acc);
        cycle(1'b1, 32'h00200013, 32'h10, 1'b1, 3'b000, 1'b0, acc);
        check("bp_hold_10", 32'(acc), 32'd0);
        tries = 0;
        while (!acc && tries < 8) begin
            cycle(1'b1, 32'h00200013, 32'h10, 1'b1, 3'b000, 1'b1, acc);
            tries++;
        end
        check("bp_acc_10", 32'(acc), 32'd1);
        repeat (4) idle(1'b1);

        // Flush while full with a new beat 0x20 offered in the same cycle.
        cycle(1'b1, 32'h11111111, 32'h18, 1'b0, 3'b000, 1'b0, acc);
        cycle(1'b1, 32'h22222222, 32'h1C, 1'b1, 3'b000, 1'b0, acc);
        cycle(1'b1, 32'h33333333, 32'h20, 1'b1, Pipe_Clear, 1'b1, acc);
        check("flush_drop_20", 32'(acc), 32'd0);
        seen20 = 1'b0;
        repeat (3) begin
            idle(1'b1);
            if (valid_if_id && addr_out == 32'h20) seen20 = 1'b1;
        end
        check("flush_never_20", 32'(seen20), 32'd0);

        // Simultaneous push/pop with one entry resident.
        cycle(1'b1, 32'h40000013, 32'h40, 1'b0, 3'b000, 1'b0, acc);
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b1, 32'h40000013 + 32'(i), 32'h40 + 32'(4 * i), 1'b0, 3'b000, 1'b1, acc);
            check("part_acc", 32'(acc), 32'd1);
        end

        // Asynchronous reset mid-cycle while holding data.
        cycle(1'b1, 32'h55555555, 32'h80, 1'b1, 3'b000, 1'b0, acc);
        cycle(1'b1, 32'h66666666, 32'h84, 1'b0, 3'b000, 1'b0, acc);
        check("pre_reset_valid", 32'(valid_if_id), 32'd1);
        inst_valid = 1'b0;
        hold_flag  = 3'b000;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        model_q.delete();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [2:0] hold;
            hold = ($urandom_range(0, 15) == 0) ? Pipe_Clear : 3'($urandom_range(0, 3));
            cycle(($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 1)),
                  hold, (i % 64 < 32) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                  acc);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
